// File: rtl/trap_ctrl_pkg.sv
// Shared types, ROB age compare and interrupt priority list for the trap controller.
package trap_ctrl_pkg;

  localparam int unsigned PTR_MAX_W = 17;
  localparam int unsigned XLEN_MAX  = 64;

  typedef logic [PTR_MAX_W-1:0] robPtr_t;
  typedef logic [5:0]           cause_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REQ
  } trap_state_t;

  typedef struct packed {
    logic                isIntr;
    cause_t              cause;
    logic [XLEN_MAX-1:0] epc;
    logic [XLEN_MAX-1:0] tval;
  } trapReq_t;

  // MEI, MSI, MTI, SEI, SSI, STI
  localparam logic [3:0] INTR_PRIO [6] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};

  // Pointers are zero-extended; bit iw is the wrap flag, bits below it the index.
  function automatic logic rob_older(input robPtr_t a, input robPtr_t b, input logic [4:0] iw);
    robPtr_t mask;
    mask = (robPtr_t'(1) << iw) - robPtr_t'(1);
    if (a[iw] == b[iw]) return (a & mask) < (b & mask);
    else                return (a & mask) > (b & mask);
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Trap request / acknowledge handshake between the trap controller and the CSR unit.
interface trap_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            o_trap_vld;
  logic            o_trap_isIntr;
  logic [5:0]      o_trap_cause;
  logic [XLEN-1:0] o_trap_epc;
  logic [XLEN-1:0] o_trap_tval;
  logic            i_trap_ack;

  modport master (
    output o_trap_vld, o_trap_isIntr, o_trap_cause, o_trap_epc, o_trap_tval,
    input  i_trap_ack
  );

  modport slave (
    input  o_trap_vld, o_trap_isIntr, o_trap_cause, o_trap_epc, o_trap_tval,
    output i_trap_ack
  );
endinterface

// File: rtl/trap_ctrl_excp_oldest_sel.sv
// Combinational pick of the oldest un-squashed exception report among N channels.
module excp_oldest_sel
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IW   = 6,
  parameter int unsigned XLEN = 64
) (
  input  logic [N-1:0]        vld,
  input  logic [N*(IW+1)-1:0] rob_idx,
  input  logic [N*6-1:0]      cause,
  input  logic [N*XLEN-1:0]   pc,
  input  logic [N*XLEN-1:0]   tval,
  input  logic                squash_vld,
  input  logic [IW:0]         squash_rob_idx,
  output logic                sel_vld,
  output logic [IW:0]         sel_rob_idx,
  output cause_t              sel_cause,
  output logic [XLEN-1:0]     sel_pc,
  output logic [XLEN-1:0]     sel_tval
);

  logic [IW:0] cur;
  logic        keep;

  // Strictly-older replacement keeps the lowest channel on equal robIdx.
  always_comb begin
    sel_vld     = 1'b0;
    sel_rob_idx = '0;
    sel_cause   = '0;
    sel_pc      = '0;
    sel_tval    = '0;
    cur         = '0;
    keep        = 1'b0;
    for (int unsigned c = 0; c < N; c++) begin
      cur  = rob_idx[c*(IW+1) +: IW+1];
      keep = vld[c] && !(squash_vld &&
             !rob_older(robPtr_t'(cur), robPtr_t'(squash_rob_idx), 5'(IW)));
      if (keep && (!sel_vld || rob_older(robPtr_t'(cur), robPtr_t'(sel_rob_idx), 5'(IW)))) begin
        sel_vld     = 1'b1;
        sel_rob_idx = cur;
        sel_cause   = cause[c*6 +: 6];
        sel_pc      = pc[c*XLEN +: XLEN];
        sel_tval    = tval[c*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: keeps the oldest exception, arbitrates it against interrupts
// and holds a trap request to the CSR unit until acknowledged.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned EXCP_CHANNELS = 4,
  parameter int unsigned ROB_SIZE      = 64,
  parameter int unsigned XLEN          = 64
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [EXCP_CHANNELS-1:0]                       i_excp_vld,
  input  logic [EXCP_CHANNELS*($clog2(ROB_SIZE)+1)-1:0]  i_excp_robIdx,
  input  logic [EXCP_CHANNELS*6-1:0]                     i_excp_cause,
  input  logic [EXCP_CHANNELS*XLEN-1:0]                  i_excp_pc,
  input  logic [EXCP_CHANNELS*XLEN-1:0]                  i_excp_tval,
  input  logic [$clog2(ROB_SIZE):0]                      i_rob_head,
  input  logic                                           i_squash_vld,
  input  logic [$clog2(ROB_SIZE):0]                      i_squash_robIdx,
  input  logic [11:0]                                    i_mip,
  input  logic [11:0]                                    i_mie,
  input  logic                                           i_global_ie,
  input  logic                                           i_intr_ok,
  input  logic [XLEN-1:0]                                i_intr_epc,
  trap_ctrl_if.master                                    trap,
  output logic                                           o_busy
);

  localparam int unsigned IW = $clog2(ROB_SIZE);

  trap_state_t     state_q, state_d;
  logic [IW:0]     rec_idx_q, rec_idx_d;
  cause_t          rec_cause_q, rec_cause_d;
  logic [XLEN-1:0] rec_pc_q, rec_pc_d;
  logic [XLEN-1:0] rec_tval_q, rec_tval_d;
  trapReq_t        req_q, req_d;

  logic            sel_vld;
  logic [IW:0]     sel_rob_idx;
  cause_t          sel_cause;
  logic [XLEN-1:0] sel_pc, sel_tval;

  logic            rec_live, excp_take, load, intr_found;
  cause_t          intr_cause;
  logic [11:0]     intr_pend;

  excp_oldest_sel #(
    .N    (EXCP_CHANNELS),
    .IW   (IW),
    .XLEN (XLEN)
  ) u_sel (
    .vld            (i_excp_vld),
    .rob_idx        (i_excp_robIdx),
    .cause          (i_excp_cause),
    .pc             (i_excp_pc),
    .tval           (i_excp_tval),
    .squash_vld     (i_squash_vld),
    .squash_rob_idx (i_squash_robIdx),
    .sel_vld        (sel_vld),
    .sel_rob_idx    (sel_rob_idx),
    .sel_cause      (sel_cause),
    .sel_pc         (sel_pc),
    .sel_tval       (sel_tval)
  );

  always_comb begin
    state_d     = state_q;
    rec_idx_d   = rec_idx_q;
    rec_cause_d = rec_cause_q;
    rec_pc_d    = rec_pc_q;
    rec_tval_d  = rec_tval_q;
    req_d       = req_q;
    rec_live    = 1'b0;
    excp_take   = 1'b0;
    load        = 1'b0;
    intr_found  = 1'b0;
    intr_cause  = '0;
    intr_pend   = i_mip & i_mie;
    for (int unsigned k = 0; k < 6; k++) begin
      if (!intr_found && intr_pend[INTR_PRIO[k]]) begin
        intr_found = 1'b1;
        intr_cause = cause_t'(INTR_PRIO[k]);
      end
    end
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        // The record exists only in HOLD; a squash kills it before head match or age compare.
        rec_live  = (state_q == ST_HOLD) && !(i_squash_vld &&
                    !rob_older(robPtr_t'(rec_idx_q), robPtr_t'(i_squash_robIdx), 5'(IW)));
        excp_take = rec_live && (rec_idx_q == i_rob_head);
        load      = sel_vld && (!rec_live ||
                    rob_older(robPtr_t'(sel_rob_idx), robPtr_t'(rec_idx_q), 5'(IW)));
        if (excp_take) begin
          state_d = ST_REQ;
          req_d   = '{isIntr: 1'b0, cause: rec_cause_q,
                      epc: XLEN_MAX'(rec_pc_q), tval: XLEN_MAX'(rec_tval_q)};
        end else if (i_intr_ok && i_global_ie && intr_found) begin
          state_d = ST_REQ;
          req_d   = '{isIntr: 1'b1, cause: intr_cause,
                      epc: XLEN_MAX'(i_intr_epc), tval: '0};
        end else if (load) begin
          state_d     = ST_HOLD;
          rec_idx_d   = sel_rob_idx;
          rec_cause_d = sel_cause;
          rec_pc_d    = sel_pc;
          rec_tval_d  = sel_tval;
        end else begin
          state_d = rec_live ? ST_HOLD : ST_IDLE;
        end
      end
      ST_REQ: begin
        if (trap.i_trap_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rec_idx_q   <= '0;
      rec_cause_q <= '0;
      rec_pc_q    <= '0;
      rec_tval_q  <= '0;
      req_q       <= '0;
    end else begin
      state_q     <= state_d;
      rec_idx_q   <= rec_idx_d;
      rec_cause_q <= rec_cause_d;
      rec_pc_q    <= rec_pc_d;
      rec_tval_q  <= rec_tval_d;
      req_q       <= req_d;
    end
  end

  assign trap.o_trap_vld    = (state_q == ST_REQ);
  assign trap.o_trap_isIntr = req_q.isIntr;
  assign trap.o_trap_cause  = req_q.cause;
  assign trap.o_trap_epc    = req_q.epc[XLEN-1:0];
  assign trap.o_trap_tval   = req_q.tval[XLEN-1:0];
  assign o_busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus randomized traffic against an age-distance model.
module tb_trap_ctrl;

  localparam int PRIO [6] = '{11, 3, 7, 9, 1, 5};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        e_vld   [4];
  logic [6:0]  e_idx   [4];
  logic [5:0]  e_cause [4];
  logic [63:0] e_pc    [4];
  logic [63:0] e_tval  [4];
  logic [6:0]  head, sq_idx;
  logic        sq_vld, gie, intr_ok;
  logic [11:0] mip, mie;
  logic [63:0] intr_epc;

  logic [3:0]   excp_vld;
  logic [27:0]  excp_idx;
  logic [23:0]  excp_cause;
  logic [255:0] excp_pc, excp_tval;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_req, m_isIntr, m_rv;
  logic [5:0]  m_cause, m_rcause;
  logic [63:0] m_epc, m_tval, m_rpc, m_rtval;
  logic [6:0]  m_rptr;

  always_comb begin
    excp_vld = '0; excp_idx = '0; excp_cause = '0; excp_pc = '0; excp_tval = '0;
    for (int c = 0; c < 4; c++) begin
      excp_vld[c]           = e_vld[c];
      excp_idx[c*7 +: 7]    = e_idx[c];
      excp_cause[c*6 +: 6]  = e_cause[c];
      excp_pc[c*64 +: 64]   = e_pc[c];
      excp_tval[c*64 +: 64] = e_tval[c];
    end
  end

  trap_ctrl_if #(.XLEN(64)) trap ();

  trap_ctrl #(.EXCP_CHANNELS(4), .ROB_SIZE(64), .XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .i_excp_vld(excp_vld), .i_excp_robIdx(excp_idx), .i_excp_cause(excp_cause),
    .i_excp_pc(excp_pc), .i_excp_tval(excp_tval),
    .i_rob_head(head), .i_squash_vld(sq_vld), .i_squash_robIdx(sq_idx),
    .i_mip(mip), .i_mie(mie), .i_global_ie(gie), .i_intr_ok(intr_ok), .i_intr_epc(intr_epc),
    .trap(trap), .o_busy(busy)
  );

  // A is older than B when B sits 1..63 slots after A on the 128-entry pointer circle.
  function automatic bit m_older(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] d;
    d = b - a;
    return (d != 7'd0) && !d[6];
  endfunction

  function automatic void model_step();
    bit          bv, found;
    logic [6:0]  bp;
    logic [5:0]  bc, ic;
    logic [63:0] bpc, bt;
    logic [11:0] pend;
    if (m_req) begin
      if (trap.i_trap_ack) begin m_req = 0; m_rv = 0; end
      return;
    end
    bv = 0; bp = '0; bc = '0; bpc = '0; bt = '0;
    for (int c = 0; c < 4; c++)
      if (e_vld[c] && !(sq_vld && !m_older(e_idx[c], sq_idx)) && (!bv || m_older(e_idx[c], bp))) begin
        bv = 1; bp = e_idx[c]; bc = e_cause[c]; bpc = e_pc[c]; bt = e_tval[c];
      end
    if (m_rv && sq_vld && !m_older(m_rptr, sq_idx)) m_rv = 0;
    pend = mip & mie; found = 0; ic = '0;
    for (int k = 5; k >= 0; k--) if (pend[PRIO[k]]) begin found = 1; ic = 6'(PRIO[k]); end
    if (m_rv && m_rptr == head) begin
      m_req = 1; m_isIntr = 0; m_cause = m_rcause; m_epc = m_rpc; m_tval = m_rtval; m_rv = 0;
    end else if (intr_ok && gie && found) begin
      m_req = 1; m_isIntr = 1; m_cause = ic; m_epc = intr_epc; m_tval = '0; m_rv = 0;
    end else if (bv && (!m_rv || m_older(bp, m_rptr))) begin
      m_rv = 1; m_rptr = bp; m_rcause = bc; m_rpc = bpc; m_rtval = bt;
    end
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    for (int c = 0; c < 4; c++) begin
      e_vld[c] = 0; e_idx[c] = '0; e_cause[c] = '0; e_pc[c] = '0; e_tval[c] = '0;
    end
    head = '0; sq_vld = 0; sq_idx = '0; mip = '0; mie = '0;
    gie = 0; intr_ok = 0; intr_epc = '0; trap.i_trap_ack = 0;
  endtask

  task automatic test_reset();
    clear_inputs(); rst = 0;
    cyc(); cyc();
    total++; if (trap.o_trap_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%0h exp=0", trap.o_trap_vld); end
    total++; if (trap.o_trap_isIntr !== 1'b0) begin bad++; $display("FAIL rst_isIntr got=%0h exp=0", trap.o_trap_isIntr); end
    total++; if (trap.o_trap_cause !== 6'd0) begin bad++; $display("FAIL rst_cause got=%0h exp=0", trap.o_trap_cause); end
    total++; if (trap.o_trap_epc !== 64'd0) begin bad++; $display("FAIL rst_epc got=%0h exp=0", trap.o_trap_epc); end
    total++; if (trap.o_trap_tval !== 64'd0) begin bad++; $display("FAIL rst_tval got=%0h exp=0", trap.o_trap_tval); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    #2 rst = 1;
    cyc();
  endtask

  task automatic test_simultaneous();
    clear_inputs(); head = 7'h03;
    e_vld[0] = 1; e_idx[0] = 7'h05; e_cause[0] = 6'd5; e_pc[0] = 64'hA000; e_tval[0] = 64'h11;
    e_vld[2] = 1; e_idx[2] = 7'h03; e_cause[2] = 6'd2; e_pc[2] = 64'hB000; e_tval[2] = 64'h22;
    cyc();
    for (int c = 0; c < 4; c++) e_vld[c] = 0;
    total++; if (trap.o_trap_vld !== 1'b0) begin bad++; $display("FAIL sim_vld_n1 got=%0h exp=0", trap.o_trap_vld); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sim_busy_n1 got=%0h exp=1", busy); end
    cyc();
    total++; if (trap.o_trap_vld !== 1'b1) begin bad++; $display("FAIL sim_vld_n2 got=%0h exp=1", trap.o_trap_vld); end
    total++; if (trap.o_trap_cause !== 6'd2) begin bad++; $display("FAIL sim_cause got=%0h exp=2", trap.o_trap_cause); end
    total++; if (trap.o_trap_epc !== 64'hB000) begin bad++; $display("FAIL sim_epc got=%0h exp=b000", trap.o_trap_epc); end
    total++; if (trap.o_trap_tval !== 64'h22) begin bad++; $display("FAIL sim_tval got=%0h exp=22", trap.o_trap_tval); end
    total++; if (trap.o_trap_isIntr !== 1'b0) begin bad++; $display("FAIL sim_isIntr got=%0h exp=0", trap.o_trap_isIntr); end
    trap.i_trap_ack = 1; cyc(); trap.i_trap_ack = 0;
    total++; if (trap.o_trap_vld !== 1'b0) begin bad++; $display("FAIL sim_ack_vld got=%0h exp=0", trap.o_trap_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sim_ack_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_wrap();
    clear_inputs(); head = 7'h3E;
    e_vld[1] = 1; e_idx[1] = 7'h42; e_cause[1] = 6'd7; e_pc[1] = 64'h100; e_tval[1] = 64'h1;
    cyc();
    e_vld[1] = 0;
    e_vld[3] = 1; e_idx[3] = 7'h3E; e_cause[3] = 6'd13; e_pc[3] = 64'h200; e_tval[3] = 64'h2;
    cyc();
    e_vld[3] = 0;
    total++; if (trap.o_trap_vld !== 1'b0) begin bad++; $display("FAIL wrap_vld_early got=%0h exp=0", trap.o_trap_vld); end
    cyc();
    total++; if (trap.o_trap_vld !== 1'b1) begin bad++; $display("FAIL wrap_vld got=%0h exp=1", trap.o_trap_vld); end
    total++; if (trap.o_trap_cause !== 6'd13) begin bad++; $display("FAIL wrap_cause got=%0h exp=d", trap.o_trap_cause); end
    total++; if (trap.o_trap_epc !== 64'h200) begin bad++; $display("FAIL wrap_epc got=%0h exp=200", trap.o_trap_epc); end
    trap.i_trap_ack = 1; cyc(); trap.i_trap_ack = 0;
  endtask

  task automatic test_squash();
    clear_inputs(); head = 7'h00;
    e_vld[0] = 1; e_idx[0] = 7'h10; e_cause[0] = 6'd4;
    cyc();
    e_vld[0] = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sq_busy_rec got=%0h exp=1", busy); end
    sq_vld = 1; sq_idx = 7'h0C;
    cyc();
    sq_vld = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sq_busy got=%0h exp=0", busy); end
    head = 7'h10;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (trap.o_trap_vld !== 1'b0) begin bad++; $display("FAIL sq_novld cyc=%0d got=%0h exp=0", i, trap.o_trap_vld); end
    end
  endtask

  task automatic test_intr_priority();
    logic [11:0] pv [7];
    logic [11:0] ev [7];
    logic [5:0]  xc [7];
    pv = '{12'h8A0, 12'h0A8, 12'h2A0, 12'h222, 12'h022, 12'h020, 12'h880};
    ev = '{12'h8A0, 12'h0A8, 12'h2A0, 12'h222, 12'h022, 12'h020, 12'h080};
    xc = '{6'd11,   6'd3,    6'd7,    6'd9,    6'd1,    6'd5,    6'd7};
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      mip = pv[i]; mie = ev[i]; gie = 1; intr_ok = 1; intr_epc = 64'hE000 + 64'(i);
      cyc();
      intr_ok = 0;
      total++; if (trap.o_trap_vld !== 1'b1) begin bad++; $display("FAIL irq_vld[%0d] got=%0h exp=1", i, trap.o_trap_vld); end
      total++; if (trap.o_trap_isIntr !== 1'b1) begin bad++; $display("FAIL irq_isIntr[%0d] got=%0h exp=1", i, trap.o_trap_isIntr); end
      total++; if (trap.o_trap_cause !== xc[i]) begin bad++; $display("FAIL irq_cause[%0d] got=%0d exp=%0d", i, trap.o_trap_cause, xc[i]); end
      total++; if (trap.o_trap_epc !== 64'hE000 + 64'(i)) begin bad++; $display("FAIL irq_epc[%0d] got=%0h", i, trap.o_trap_epc); end
      total++; if (trap.o_trap_tval !== 64'd0) begin bad++; $display("FAIL irq_tval[%0d] got=%0h exp=0", i, trap.o_trap_tval); end
      trap.i_trap_ack = 1; cyc(); trap.i_trap_ack = 0;
    end
    clear_inputs(); mip = 12'h080; mie = 12'h080; gie = 0; intr_ok = 1;
    cyc();
    total++; if (trap.o_trap_vld !== 1'b0) begin bad++; $display("FAIL irq_gie_off got=%0h exp=0", trap.o_trap_vld); end
  endtask

  task automatic test_conflict();
    clear_inputs(); head = 7'h20;
    e_vld[1] = 1; e_idx[1] = 7'h20; e_cause[1] = 6'd6; e_pc[1] = 64'hC100; e_tval[1] = 64'h66;
    cyc();
    e_vld[1] = 0;
    mip = 12'h080; mie = 12'h080; gie = 1; intr_ok = 1; intr_epc = 64'hD000;
    cyc();
    total++; if (trap.o_trap_isIntr !== 1'b0) begin bad++; $display("FAIL cf_isIntr got=%0h exp=0", trap.o_trap_isIntr); end
    total++; if (trap.o_trap_cause !== 6'd6) begin bad++; $display("FAIL cf_cause got=%0h exp=6", trap.o_trap_cause); end
    intr_ok = 0; trap.i_trap_ack = 1; cyc(); trap.i_trap_ack = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cf_idle got=%0h exp=0", busy); end
    intr_ok = 1;
    cyc();
    total++; if (trap.o_trap_isIntr !== 1'b1) begin bad++; $display("FAIL cf_mti_isIntr got=%0h exp=1", trap.o_trap_isIntr); end
    total++; if (trap.o_trap_cause !== 6'd7) begin bad++; $display("FAIL cf_mti_cause got=%0h exp=7", trap.o_trap_cause); end
    total++; if (trap.o_trap_epc !== 64'hD000) begin bad++; $display("FAIL cf_mti_epc got=%0h exp=d000", trap.o_trap_epc); end
    intr_ok = 0; trap.i_trap_ack = 1; cyc(); trap.i_trap_ack = 0;
  endtask

  task automatic test_handshake();
    clear_inputs(); head = 7'h30;
    e_vld[0] = 1; e_idx[0] = 7'h30; e_cause[0] = 6'd9; e_pc[0] = 64'hC000; e_tval[0] = 64'h33;
    cyc(); e_vld[0] = 0; cyc();
    for (int i = 0; i < 5; i++) begin
      e_vld[2] = 1; e_idx[2] = 7'h2F; e_cause[2] = 6'(i); e_pc[2] = 64'(i);
      sq_vld = (i == 2); sq_idx = 7'h28;
      cyc();
      total++; if (trap.o_trap_vld !== 1'b1) begin bad++; $display("FAIL hs_vld[%0d] got=%0h exp=1", i, trap.o_trap_vld); end
      total++; if (trap.o_trap_cause !== 6'd9) begin bad++; $display("FAIL hs_cause[%0d] got=%0h exp=9", i, trap.o_trap_cause); end
      total++; if (trap.o_trap_epc !== 64'hC000) begin bad++; $display("FAIL hs_epc[%0d] got=%0h exp=c000", i, trap.o_trap_epc); end
      total++; if (trap.o_trap_tval !== 64'h33) begin bad++; $display("FAIL hs_tval[%0d] got=%0h exp=33", i, trap.o_trap_tval); end
    end
    clear_inputs(); head = 7'h30;
    trap.i_trap_ack = 1; cyc(); trap.i_trap_ack = 0;
    total++; if (trap.o_trap_vld !== 1'b0) begin bad++; $display("FAIL hs_ack_vld got=%0h exp=0", trap.o_trap_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hs_ack_busy got=%0h exp=0", busy); end
    mip = 12'h008; mie = 12'h008; gie = 1; intr_ok = 1; intr_epc = 64'hF0;
    cyc();
    total++; if (trap.o_trap_vld !== 1'b1) begin bad++; $display("FAIL hs_req2 got=%0h exp=1", trap.o_trap_vld); end
    #2 rst = 0; #1;
    total++; if (trap.o_trap_vld !== 1'b0) begin bad++; $display("FAIL hs_arst_vld got=%0h exp=0", trap.o_trap_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hs_arst_busy got=%0h exp=0", busy); end
    total++; if (trap.o_trap_cause !== 6'd0) begin bad++; $display("FAIL hs_arst_cause got=%0h exp=0", trap.o_trap_cause); end
    total++; if (trap.o_trap_epc !== 64'd0) begin bad++; $display("FAIL hs_arst_epc got=%0h exp=0", trap.o_trap_epc); end
    clear_inputs();
    #2 rst = 1;
    cyc();
    total++; if (trap.o_trap_vld !== 1'b0) begin bad++; $display("FAIL hs_post_rst got=%0h exp=0", trap.o_trap_vld); end
  endtask

  task automatic test_random();
    clear_inputs(); rst = 0; cyc(); #2 rst = 1; cyc();
    m_req = 0; m_rv = 0; m_isIntr = 0; m_cause = '0; m_epc = '0; m_tval = '0;
    head = 7'(($urandom_range(0, 127)));
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 0) head = head + 7'($urandom_range(1, 2));
      for (int c = 0; c < 4; c++) begin
        e_vld[c]   = ($urandom_range(0, 3) == 0);
        e_idx[c]   = head + 7'($urandom_range(0, 5));
        e_cause[c] = 6'($urandom);
        e_pc[c]    = {$urandom, $urandom};
        e_tval[c]  = {$urandom, $urandom};
      end
      sq_vld   = ($urandom_range(0, 9) == 0);
      sq_idx   = head + 7'($urandom_range(0, 5));
      mip      = 12'($urandom) & 12'h8AA;
      mie      = 12'($urandom) & 12'h8AA;
      gie      = 1'($urandom_range(0, 1));
      intr_ok  = ($urandom_range(0, 7) == 0);
      intr_epc = {$urandom, $urandom};
      trap.i_trap_ack = ($urandom_range(0, 2) == 0);
      model_step();
      cyc();
      total++; if (trap.o_trap_vld !== m_req) begin bad++; $display("FAIL rnd_vld n=%0d got=%0h exp=%0h", n, trap.o_trap_vld, m_req); end
      total++; if (busy !== (m_req || m_rv)) begin bad++; $display("FAIL rnd_busy n=%0d got=%0h exp=%0h", n, busy, m_req || m_rv); end
      if (m_req) begin
        total++; if (trap.o_trap_isIntr !== m_isIntr) begin bad++; $display("FAIL rnd_isIntr n=%0d got=%0h exp=%0h", n, trap.o_trap_isIntr, m_isIntr); end
        total++; if (trap.o_trap_cause !== m_cause) begin bad++; $display("FAIL rnd_cause n=%0d got=%0h exp=%0h", n, trap.o_trap_cause, m_cause); end
        total++; if (trap.o_trap_epc !== m_epc) begin bad++; $display("FAIL rnd_epc n=%0d got=%0h exp=%0h", n, trap.o_trap_epc, m_epc); end
        total++; if (trap.o_trap_tval !== m_tval) begin bad++; $display("FAIL rnd_tval n=%0d got=%0h exp=%0h", n, trap.o_trap_tval, m_tval); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_wrap();
    test_squash();
    test_intr_priority();
    test_conflict();
    test_handshake();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
